// File: rtl/d_latch_checker.sv
// rtl/d_latch_checker.sv - self-checking monitor for a level-sensitive D latch
//
// Purpose:
//   Samples a latch's D, En and Q every clock, runs a reference model of
//   transparent/hold behaviour and flags, counts and timestamps every Q
//   mismatch. Stage 1 registers the raw inputs with their sample index;
//   stage 2 runs the model FSM and the checker on those samples.
//
// Ports:
//   i_clk             single clock, all logic on posedge
//   i_rst             synchronous active-high reset
//   i_d, i_en, i_q    latch D, enable (as driven) and Q (as observed)
//   i_chk_en          1 = compare and flag, 0 = track model state only
//   i_clr             synchronous clear of error status (not model state)
//   o_err_pulse       one-cycle pulse per detected mismatch
//   o_err_sticky      set on any mismatch, held until clr/rst
//   o_err_count       saturating mismatch count since rst/clr
//   o_first_err_valid o_first_err_cyc holds a captured sample index
//   o_first_err_cyc   sample index of the first mismatch since rst/clr
//   o_state           model state: 0 UNKNOWN, 1 TRANSPARENT, 2 HOLD

module d_latch_checker #(
  parameter int ERR_CNT_W = 8,
  parameter int CYC_W     = 16,
  parameter int SETTLE    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_d,
  input  logic                 i_en,
  input  logic                 i_q,
  input  logic                 i_chk_en,
  input  logic                 i_clr,
  output logic                 o_err_pulse,
  output logic                 o_err_sticky,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_first_err_valid,
  output logic [CYC_W-1:0]     o_first_err_cyc,
  output logic [1:0]           o_state
);

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_TRANS   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [CYC_W-1:0]     CYC_MAX   = {CYC_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
  localparam logic [2:0]           SETTLE_LD = 3'(SETTLE);

  // Stage 1: raw samples plus the index each one was taken at
  logic             r_d_s;
  logic             r_en_s;
  logic             r_q_s;
  logic             r_chk_s;
  logic [CYC_W-1:0] r_idx_s;
  logic [CYC_W-1:0] r_cyc;

  // Stage 2: model state and error status
  logic [1:0]           r_state;
  logic                 r_d_prev;
  logic                 r_held;
  logic [2:0]           r_settle;
  logic                 r_err_pulse;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_first_valid;
  logic [CYC_W-1:0]     r_first_cyc;

  logic [1:0] w_state_nxt;
  logic       w_settle_ld;
  logic [2:0] w_settle_eff;
  logic       w_held_nxt;
  logic       w_exp;
  logic       w_checked;
  logic       w_mismatch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d_s   <= 1'b0;
      r_en_s  <= 1'b0;
      r_q_s   <= 1'b0;
      r_chk_s <= 1'b0;
      r_idx_s <= '0;
      r_cyc   <= '0;
    end else begin
      r_d_s   <= i_d;
      r_en_s  <= i_en;
      r_q_s   <= i_q;
      r_chk_s <= i_chk_en;
      r_idx_s <= r_cyc;
      if (r_cyc != CYC_MAX) begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

  // FSM process 1: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_UNKNOWN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM process 2: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNKNOWN: if (r_en_s)  w_state_nxt = ST_TRANS;
      ST_TRANS:   if (!r_en_s) w_state_nxt = ST_HOLD;
      ST_HOLD:    if (r_en_s)  w_state_nxt = ST_TRANS;
      default:    w_state_nxt = ST_UNKNOWN;
    endcase
  end

  // FSM process 3: outputs
  always_comb begin
    o_state = r_state;
  end

  // The sample being judged is classified by the state it moves the model
  // into, so the first transparent sample and the first hold sample are
  // both judged under their new behaviour.
  always_comb begin
    w_settle_ld  = (w_state_nxt == ST_TRANS) &&
                   ((r_state != ST_TRANS) || (r_d_s != r_d_prev));
    w_settle_eff = w_settle_ld ? SETTLE_LD : r_settle;
    // Leaving TRANSPARENT: the last transparent sample's D is what got held
    w_held_nxt   = ((r_state == ST_TRANS) && (w_state_nxt == ST_HOLD)) ?
                   r_d_prev : r_held;
    w_exp        = (w_state_nxt == ST_HOLD) ? w_held_nxt : r_d_s;
    w_checked    = (w_state_nxt == ST_HOLD) ||
                   ((w_state_nxt == ST_TRANS) && (w_settle_eff == 3'd0));
    // Case inequality so an X/Z on Q is reported rather than masked
    w_mismatch   = w_checked && r_chk_s && (r_q_s !== w_exp);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d_prev <= 1'b0;
      r_held   <= 1'b0;
      r_settle <= 3'd0;
    end else begin
      r_d_prev <= r_d_s;
      r_held   <= w_held_nxt;
      r_settle <= (w_settle_eff != 3'd0) ? (w_settle_eff - 3'd1) : 3'd0;
    end
  end

  // Error status; a mismatch on the same edge as clr wins over the clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_cyc   <= '0;
    end else begin
      r_err_pulse <= w_mismatch;

      if (w_mismatch) begin
        r_err_sticky <= 1'b1;
      end else if (i_clr) begin
        r_err_sticky <= 1'b0;
      end

      if (i_clr) begin
        r_err_count <= w_mismatch ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (w_mismatch && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end

      if (w_mismatch && (!r_first_valid || i_clr)) begin
        r_first_valid <= 1'b1;
        r_first_cyc   <= r_idx_s;
      end else if (i_clr) begin
        r_first_valid <= 1'b0;
      end
    end
  end

  assign o_err_pulse       = r_err_pulse;
  assign o_err_sticky      = r_err_sticky;
  assign o_err_count       = r_err_count;
  assign o_first_err_valid = r_first_valid;
  assign o_first_err_cyc   = r_first_cyc;

endmodule

// File: tb/tb_d_latch_checker.sv
// tb/tb_d_latch_checker.sv - directed table-driven bench for d_latch_checker

module tb_d_latch_checker;

  logic       clk;
  logic       rst;
  logic       d;
  logic       en;
  logic       q;
  logic       chk_en;
  logic       clr;
  logic       err_pulse;
  logic       err_sticky;
  logic [3:0] err_count;
  logic       first_err_valid;
  logic [15:0] first_err_cyc;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       d;
    logic       en;
    logic       q;
    logic       chk;
    logic       clr;
    logic       pulse;
    logic [3:0] count;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [18];

  d_latch_checker #(
    .ERR_CNT_W (4),
    .CYC_W     (16),
    .SETTLE    (1)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_d               (d),
    .i_en              (en),
    .i_q               (q),
    .i_chk_en          (chk_en),
    .i_clr             (clr),
    .o_err_pulse       (err_pulse),
    .o_err_sticky      (err_sticky),
    .o_err_count       (err_count),
    .o_first_err_valid (first_err_valid),
    .o_first_err_cyc   (first_err_cyc),
    .o_state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic dd, input logic ee, input logic qq,
                       input logic cc, input logic cl);
    rst = r; d = dd; en = ee; q = qq; chk_en = cc; clr = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic lq;
    logic dd;
    logic ee;
    logic qq;

    // Each row: inputs for this edge, then outputs expected after it
    // (which reflect the verdict of the previous row's sample).
    //          rst d  en q  chk clr  pulse count st
    tbl[0]  = '{1, 0, 0, 0, 1, 0,   0, 4'd0, 2'd0};
    tbl[1]  = '{0, 0, 1, 0, 1, 0,   0, 4'd0, 2'd0};
    tbl[2]  = '{0, 0, 1, 0, 1, 0,   0, 4'd0, 2'd1};
    tbl[3]  = '{0, 1, 1, 0, 1, 0,   0, 4'd0, 2'd1};
    tbl[4]  = '{0, 1, 1, 1, 1, 0,   0, 4'd0, 2'd1};
    tbl[5]  = '{0, 0, 1, 1, 1, 0,   0, 4'd0, 2'd1};
    tbl[6]  = '{0, 0, 1, 1, 1, 0,   0, 4'd0, 2'd1};
    tbl[7]  = '{0, 0, 1, 0, 1, 0,   1, 4'd1, 2'd1};
    tbl[8]  = '{0, 1, 1, 0, 0, 0,   0, 4'd1, 2'd1};
    tbl[9]  = '{0, 1, 1, 0, 0, 0,   0, 4'd1, 2'd1};
    tbl[10] = '{0, 1, 1, 1, 1, 0,   0, 4'd1, 2'd1};
    tbl[11] = '{0, 0, 0, 1, 1, 0,   0, 4'd1, 2'd1};
    tbl[12] = '{0, 0, 0, 0, 1, 0,   0, 4'd1, 2'd2};
    tbl[13] = '{0, 0, 0, 1, 1, 0,   1, 4'd2, 2'd2};
    tbl[14] = '{0, 1, 0, 0, 1, 1,   0, 4'd0, 2'd2};
    tbl[15] = '{0, 1, 0, 1, 1, 0,   1, 4'd1, 2'd2};
    tbl[16] = '{0, 1, 1, 1, 1, 0,   0, 4'd1, 2'd2};
    tbl[17] = '{0, 1, 1, 1, 1, 0,   0, 4'd1, 2'd1};

    // Reset with random stimulus
    drive(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1, 0);
      tick();
    end
    check("rst_state", state, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_count", err_count, 0);
    check("rst_first_valid", first_err_valid, 0);
    check("rst_first_cyc", first_err_cyc, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'($urandom % 2), 0, 1'($urandom % 2), 1, 0);
      tick();
      check("unknown_state", state, 0);
      check("unknown_pulse", err_pulse, 0);
    end
    check("unknown_count", err_count, 0);

    // Clean latch: transparent with d toggling, then hold with d toggling
    lq = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ee = (i < 40);
      dd = (((i / 10) % 2) == 1);
      if (ee) lq = dd;
      drive(0, dd, ee, lq, 1, 0);
      tick();
      check("clean_pulse", err_pulse, 0);
      if (i == 39) check("clean_state_trans", state, 1);
    end
    check("clean_state_hold", state, 2);
    check("clean_count", err_count, 0);
    check("clean_sticky", err_sticky, 0);

    // Settle, chk_en, hold mismatch and clr vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].d, tbl[i].en, tbl[i].q, tbl[i].chk, tbl[i].clr);
      tick();
      check($sformatf("vec%0d_pulse", i), err_pulse, tbl[i].pulse);
      check($sformatf("vec%0d_count", i), err_count, tbl[i].count);
      check($sformatf("vec%0d_state", i), state, tbl[i].st);
    end

    // Saturation: 20 consecutive mismatches against a 4-bit counter
    drive(0, 1, 1, 1, 1, 1);
    tick();
    check("sat_pre_count", err_count, 0);
    for (int i = 0; i < 22; i++) begin
      drive(0, 1, 1, (i < 20) ? 1'b0 : 1'b1, 1, 0);
      tick();
      check($sformatf("sat_pulse%0d", i), err_pulse, (i >= 1 && i <= 20) ? 1 : 0);
    end
    check("sat_count", err_count, 15);
    check("sat_sticky", err_sticky, 1);

    // Hold violation at sample 20, more errors, clr racing a mismatch at 50,
    // then reset in the middle of HOLD
    drive(1, 0, 0, 0, 1, 0);
    tick();
    for (int s = 0; s < 53; s++) begin
      ee = (s < 10);
      dd = ee ? 1'b1 : ((s % 2) == 1);
      qq = (s == 20 || s == 30 || s == 40 || s == 50) ? 1'b0 : 1'b1;
      drive(0, dd, ee, qq, 1, (s == 51));
      tick();
      if (s == 10) check("hv_state_trans", state, 1);
      if (s == 11) check("hv_state_hold", state, 2);
      if (s == 20) check("hv_pulse_early", err_pulse, 0);
      if (s == 21) begin
        check("hv_pulse", err_pulse, 1);
        check("hv_count", err_count, 1);
        check("hv_first_valid", first_err_valid, 1);
        check("hv_first_cyc", first_err_cyc, 20);
      end
      if (s == 22) check("hv_pulse_late", err_pulse, 0);
      if (s == 50) begin
        check("pre_clr_count", err_count, 3);
        check("pre_clr_first_cyc", first_err_cyc, 20);
      end
      if (s == 51) begin
        check("clr_race_pulse", err_pulse, 1);
        check("clr_race_count", err_count, 1);
        check("clr_race_sticky", err_sticky, 1);
        check("clr_race_first_valid", first_err_valid, 1);
        check("clr_race_first_cyc", first_err_cyc, 50);
      end
      if (s == 52) check("post_clr_state", state, 2);
    end
    drive(1, 1, 0, 0, 1, 0);
    tick();
    check("midrst_state", state, 0);
    check("midrst_pulse", err_pulse, 0);
    check("midrst_sticky", err_sticky, 0);
    check("midrst_count", err_count, 0);
    check("midrst_first_valid", first_err_valid, 0);
    check("midrst_first_cyc", first_err_cyc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_latch_checker.md
# d_latch_checker

Synchronous self-checking monitor for the level-sensitive D latch: it samples the latch's D, En and Q on every clock, runs a reference model of transparent/hold behaviour, and flags, counts and timestamps every Q mismatch. It is the observing end of the latch stimulus benches. A bench instantiates it next to the latch so pass/fail comes from hardware counters instead of reading waveforms.

## Interface
- ERR_CNT_W, 8: width of the saturating error counter.
- CYC_W, 16: width of the saturating sample-index counter and the first-error timestamp.
- SETTLE, 1: samples skipped after entering TRANSPARENT or after a D change while transparent (legal 0..7).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- d  in  1  latch D input, as driven to the DUT.
- en  in  1  latch enable, as driven to the DUT.
- q  in  1  latch Q output from the DUT.
- chk_en  in  1  1 = compare and flag; 0 = track state only.
- clr  in  1  synchronous clear of error status (not of the model state).
- err_pulse  out  1  one-cycle pulse per detected mismatch.
- err_sticky  out  1  set on any mismatch; held until clr or rst.
- err_count  out  ERR_CNT_W  mismatches since rst/clr; saturates at all-ones.
- first_err_valid  out  1  first_err_cyc holds a valid value.
- first_err_cyc  out  CYC_W  sample index of the first mismatch since rst/clr.
- state  out  2  model state: 0 UNKNOWN, 1 TRANSPARENT, 2 HOLD.

## Operation
- Stage 1: d, en, q are registered into d_s, en_s, q_s every cycle. The sample index cyc increments per sample and saturates at all-ones.
- Stage 2: the FSM and checker act on the stage-1 samples.
- FSM:
  - UNKNOWN→TRANSPARENT when en_s=1.
  - TRANSPARENT→HOLD when en_s=0, latching held = the d_s of the previous sample (the last sample with en_s=1).
  - HOLD→TRANSPARENT when en_s=1.
  - UNKNOWN persists while en_s=0.
  - No other transitions.
- Expected value:
  - TRANSPARENT: exp = d_s.
  - HOLD: exp = held.
  - UNKNOWN: no check, because the latch content is undefined.
- Settle counter:
  - Loaded with SETTLE on entry to TRANSPARENT.
  - Also loaded when d_s differs from the previous d_s while TRANSPARENT.
  - The check is suppressed while the counter is nonzero; the counter decrements each sample.
  - SETTLE=0 means check immediately.
  - HOLD has no settle; it is checked from its entry sample onward.
- Mismatch:
  - A mismatch is a checked sample with chk_en=1 and q_s ≠ exp.
  - q_s of X or Z counts as a mismatch, using case inequality in simulation.
- On a mismatch:
  - err_pulse=1 for one cycle.
  - err_sticky=1.
  - err_count increments, saturating.
  - If first_err_valid=0, capture first_err_cyc = sample index and set first_err_valid=1.
- clr:
  - Clears err_sticky, err_count and first_err_valid in the same edge.
  - If a mismatch is detected on that same edge, the error wins: count=1, sticky=1, first_err_cyc captured.
  - clr does not touch the FSM, held, cyc or the settle counter.
- chk_en=0: the FSM and settle counter keep running; err_pulse stays 0 and no status changes.

## Timing
- Reset values:
  - state=0.
  - err_pulse=0, err_sticky=0, err_count=0.
  - first_err_valid=0, first_err_cyc=0.
  - Internal: cyc=0, held=0, settle=0, d_s/en_s/q_s=0.
- Latency: inputs present before edge k are sampled at edge k (sample index = cyc value at edge k).
  - The verdict registers at edge k+1.
  - err_pulse is high from edge k+1 to edge k+2.
  - state reflects the sample from edge k after edge k+1.
- Back-to-back mismatches give err_pulse held high across consecutive cycles, one count per cycle.
- rst mid-operation: every register returns to its reset value on that edge.
  - The first post-reset sample occurs on the first edge with rst=0.
  - No check happens until the FSM leaves UNKNOWN.
- Saturation: err_count and cyc hold at all-ones. Further errors still pulse and set sticky.

## Test plan
- Reset: hold rst=1 for 2 cycles with random d/en/q. Required: state=0, err_pulse=0, err_sticky=0, err_count=0, first_err_valid=0. Then release with en=0 for 5 cycles: no errors, state stays 0.
- Clean latch: connect a correct latch model, with en=1 for 40 cycles and d toggling every 10 cycles, then en=0 for 40 cycles with d toggling. Required: state goes 1 then 2, err_count=0 at end, err_sticky=0.
- Hold violation: hold with held=1 and force q=0 for exactly the sample with index 20. Required: err_pulse high one cycle, 2 edges after that sample; err_count=1; first_err_valid=1; first_err_cyc=20.
- Settle (SETTLE=1, en=1):
  - d 0→1 with q lagging one sample: err_count=0.
  - q lagging two samples: err_count=1.
  - Same 2-sample lag with chk_en=0: err_count=0.
- Saturation (ERR_CNT_W=4): 20 consecutive mismatching samples. Required: err_count=15, err_pulse high 20 consecutive cycles.
- clr and rst:
  - clr asserted on the same edge as a new mismatch at sample 50, after 3 prior errors. Required: err_count=1, err_sticky=1, first_err_cyc=50.
  - Then rst mid-HOLD. Required: all outputs at reset values, state=0.
